tbman_periph: RTL and testbench

//  Memory-mapped testbench manager (TBMAN) on the CPU data bus, beside data memory.

---
 rtl/tbman_periph_pkg.sv | 41 ++++
 rtl/tbman_char_fifo.sv | 51 +++++
 rtl/tbman_periph.sv | 141 ++++++++++++++
 tb/tb_tbman_periph.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbman_periph_pkg.sv
// Shared definitions for the TBMAN peripheral: register word indices, CTRL bit
// positions and the address-to-register decode helper.
package tbman_periph_pkg;

  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_PUTC      = 1;
  localparam int unsigned REG_CYCLE_LO  = 2;
  localparam int unsigned REG_CYCLE_HI  = 3;
  localparam int unsigned REG_SCRATCH   = 4;
  localparam int unsigned REG_TIMER_CMP = 5;

  localparam int CTRL_DONE = 0;
  localparam int CTRL_PASS = 1;
  localparam int CTRL_OVF  = 2;
  localparam int CTRL_TEN  = 3;
  localparam int CTRL_IRQ  = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_PUTC,
    SEL_CYCLE_LO,
    SEL_CYCLE_HI,
    SEL_SCRATCH,
    SEL_TIMER_CMP
  } reg_sel_e;

  // Word index (byte offset with the two lsbs dropped) to register select.
  function automatic reg_sel_e decode_word(input int unsigned idx);
    case (idx)
      REG_CTRL:      return SEL_CTRL;
      REG_PUTC:      return SEL_PUTC;
      REG_CYCLE_LO:  return SEL_CYCLE_LO;
      REG_CYCLE_HI:  return SEL_CYCLE_HI;
      REG_SCRATCH:   return SEL_SCRATCH;
      REG_TIMER_CMP: return SEL_TIMER_CMP;
      default:       return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tbman_char_fifo.sv
// Synchronous byte FIFO for the console; head byte reads as 0 while empty so the
// char_data output is clean after reset.
module tbman_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? 8'h00 : mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/tbman_periph.sv
// Memory-mapped testbench manager: console FIFO, sim-done/pass flags, 64-bit cycle
// counter with coherent high-word shadow, and a compare timer interrupt.
module tbman_periph
  import tbman_periph_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cs_tbman_n,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data_tbman,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              sim_done,
  output logic              sim_pass,
  output logic              timer_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e      sel;
  logic          acc_wr;
  logic          acc_rd;
  logic          ctrl_wr;
  logic          putc_wr;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;
  logic [CW-1:0] fifo_count;
  logic [31:0]   rd_next;

  logic          timer_en;
  logic          ovf;
  logic [63:0]   cycle_cnt;
  logic [31:0]   hi_shadow;
  logic [31:0]   scratch;
  logic [31:0]   timer_cmp;

  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  always_comb begin
    sel      = decode_word(32'(addr[ADDR_W-1:2]));
    acc_wr   = !cs_tbman_n && we;
    acc_rd   = !cs_tbman_n && !we;
    ctrl_wr  = acc_wr && (sel == SEL_CTRL);
    putc_wr  = acc_wr && (sel == SEL_PUTC);
    fifo_pop = char_valid && char_ready;
    fifo_drop = putc_wr && fifo_full && !fifo_pop;
  end

  assign char_valid = !fifo_empty;

  tbman_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (putc_wr),
    .pop   (fifo_pop),
    .wdata (write_data[7:0]),
    .rdata (char_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_next = 32'h0;
    case (sel)
      SEL_CTRL:      rd_next = {27'b0, timer_irq, timer_en, ovf, sim_pass, sim_done};
      SEL_PUTC:      rd_next = 32'(fifo_count);
      SEL_CYCLE_LO:  rd_next = cycle_cnt[31:0];
      SEL_CYCLE_HI:  rd_next = hi_shadow;
      SEL_SCRATCH:   rd_next = scratch;
      SEL_TIMER_CMP: rd_next = timer_cmp;
      default:       rd_next = 32'h0;
    endcase
  end

  // Interrupt and overflow sets take priority over their W1C clears.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      read_data_tbman <= '0;
      sim_done        <= 1'b0;
      sim_pass        <= 1'b0;
      timer_irq       <= 1'b0;
      timer_en        <= 1'b0;
      ovf             <= 1'b0;
      cycle_cnt       <= '0;
      hi_shadow       <= '0;
      scratch         <= '0;
      timer_cmp       <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;

      if (ctrl_wr) begin
        timer_en <= write_data[CTRL_TEN];
        if (!sim_done && write_data[CTRL_DONE]) begin
          sim_done <= 1'b1;
          sim_pass <= write_data[CTRL_PASS];
        end
      end

      if (fifo_drop) begin
        ovf <= 1'b1;
      end else if (ctrl_wr && write_data[CTRL_OVF]) begin
        ovf <= 1'b0;
      end

      if (timer_en && (cycle_cnt[31:0] == timer_cmp)) begin
        timer_irq <= 1'b1;
      end else if (ctrl_wr && write_data[CTRL_IRQ]) begin
        timer_irq <= 1'b0;
      end

      if (acc_wr && (sel == SEL_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) scratch[8*b +: 8] <= write_data[8*b +: 8];
        end
      end
      if (acc_wr && (sel == SEL_TIMER_CMP)) begin
        timer_cmp <= write_data;
      end

      // Reading the low word freezes the high word so a LO/HI pair is coherent.
      if (acc_rd) begin
        read_data_tbman <= rd_next;
        if (sel == SEL_CYCLE_LO) hi_shadow <= cycle_cnt[63:32];
      end
    end
  end

endmodule

// File: tb/tb_tbman_periph.sv
// Directed self-checking bench for tbman_periph: console FIFO, flags, cycle
// counter coherence, compare timer and reset behaviour.
module tb_tbman_periph;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cs_tbman_n = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data_tbman;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        sim_done;
  logic        sim_pass;
  logic        timer_irq;

  int testCount = 0;
  int failCount = 0;
  int edgeNum = 0;

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_PUTC = 8'h04;
  localparam logic [7:0] A_LO   = 8'h08;
  localparam logic [7:0] A_HI   = 8'h0C;
  localparam logic [7:0] A_SCR  = 8'h10;
  localparam logic [7:0] A_CMP  = 8'h14;

  tbman_periph #(
    .ADDR_W     (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .cs_tbman_n      (cs_tbman_n),
    .we              (we),
    .be              (be),
    .addr            (addr),
    .write_data      (write_data),
    .read_data_tbman (read_data_tbman),
    .char_valid      (char_valid),
    .char_data       (char_data),
    .char_ready      (char_ready),
    .sim_done        (sim_done),
    .sim_pass        (sim_pass),
    .timer_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the cycle counter's value before edge k is k-1.
  always @(posedge clk) begin
    if (!n_rst) edgeNum <= 0;
    else edgeNum <= edgeNum + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] byteEn, output logic [31:0] rdata);
    @(negedge clk);
    cs_tbman_n = 1'b0;
    we = isWrite;
    addr = a;
    write_data = d;
    be = byteEn;
    @(posedge clk);
    #1;
    cs_tbman_n = 1'b1;
    we = 1'b0;
    rdata = read_data_tbman;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] unusedData;
    applyStimulus(1'b1, a, d, 4'hF, unusedData);
  endtask

  task automatic busRead(input logic [7:0] a, output logic [31:0] d);
    applyStimulus(1'b0, a, 32'h0, 4'h0, d);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] dummy;
    logic [31:0] cmpVal;
    int riseEdge;
    int n;
    logic [7:0] drainExp [8];

    // Reset state
    applyReset();
    checkOutput("reset read_data", read_data_tbman, 32'h0);
    checkOutput("reset char_valid", 32'(char_valid), 32'h0);
    checkOutput("reset char_data", 32'(char_data), 32'h0);
    checkOutput("reset sim_done", 32'(sim_done), 32'h0);
    checkOutput("reset sim_pass", 32'(sim_pass), 32'h0);
    checkOutput("reset timer_irq", 32'(timer_irq), 32'h0);
    idleCycle();
    idleCycle();
    busRead(A_LO, rd);
    checkOutput("cycle_lo after reset", rd, 32'd2);

    // Timer match at counter == 50, which is reset-release edge 51
    busWrite(A_CMP, 32'd50);
    busWrite(A_CTRL, 32'h8);
    checkOutput("irq before match", 32'(timer_irq), 32'h0);
    riseEdge = 0;
    for (int i = 0; i < 100; i++) begin
      idleCycle();
      if (timer_irq) begin
        riseEdge = edgeNum;
        break;
      end
    end
    checkOutput("irq rise edge", 32'(riseEdge), 32'd51);
    busWrite(A_CTRL, 32'h18);
    checkOutput("irq w1c clear", 32'(timer_irq), 32'h0);

    // Clear in the same cycle as a new match: the set must win
    n = edgeNum;
    cmpVal = 32'(n + 2);
    busWrite(A_CMP, cmpVal);
    idleCycle();
    busWrite(A_CTRL, 32'h18);
    checkOutput("irq set beats clear", 32'(timer_irq), 32'h1);
    busRead(A_CMP, rd);
    checkOutput("timer_cmp readback", rd, cmpVal);
    busRead(A_LO, rd);
    checkOutput("cycle_lo running", rd, 32'(edgeNum - 1));

    // Console: two bytes held, then drained
    char_ready = 1'b0;
    busWrite(A_PUTC, 32'h48);
    busWrite(A_PUTC, 32'h69);
    busRead(A_PUTC, rd);
    checkOutput("putc count 2", rd, 32'd2);
    checkOutput("head valid", 32'(char_valid), 32'h1);
    checkOutput("head 0x48", 32'(char_data), 32'h48);
    @(negedge clk);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("head 0x69", 32'(char_data), 32'h69);
    checkOutput("valid after 1 pop", 32'(char_valid), 32'h1);
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    checkOutput("valid after drain", 32'(char_valid), 32'h0);

    // Overflow: nine pushes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) busWrite(A_PUTC, 32'h30 + 32'(i));
    busRead(A_PUTC, rd);
    checkOutput("putc count full", rd, 32'd8);
    busRead(A_CTRL, rd);
    checkOutput("status ovf set", rd, 32'h1C);
    busWrite(A_CTRL, 32'h4);
    busRead(A_CTRL, rd);
    checkOutput("status ovf cleared", rd, 32'h10);

    // Push into a full FIFO while the head pops: accepted, no overflow
    @(negedge clk);
    char_ready = 1'b1;
    cs_tbman_n = 1'b0;
    we = 1'b1;
    addr = A_PUTC;
    write_data = 32'h39;
    @(posedge clk);
    #1;
    cs_tbman_n = 1'b1;
    we = 1'b0;
    char_ready = 1'b0;
    busRead(A_PUTC, rd);
    checkOutput("count full after push+pop", rd, 32'd8);
    busRead(A_CTRL, rd);
    checkOutput("no ovf on push+pop", rd, 32'h10);

    drainExp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h39};
    @(negedge clk);
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain valid %0d", i), 32'(char_valid), 32'h1);
      checkOutput($sformatf("drain byte %0d", i), 32'(char_data), 32'(drainExp[i]));
      @(negedge clk);
    end
    char_ready = 1'b0;
    checkOutput("fifo empty after drain", 32'(char_valid), 32'h0);

    // Counter coherence across the 32-bit boundary
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    busRead(A_LO, rd);
    release dut.cycle_cnt;
    checkOutput("cycle_lo at boundary", rd, 32'hFFFF_FFFF);
    busRead(A_HI, rd);
    checkOutput("cycle_hi shadow", rd, 32'h0);

    // Scratch byte enables; read data holds across writes
    busWrite(A_SCR, 32'hAABB_CCDD);
    applyStimulus(1'b1, A_SCR, 32'h1122_3344, 4'b0101, dummy);
    busRead(A_SCR, rd);
    checkOutput("scratch byte enables", rd, 32'hAA22_CC44);
    busWrite(A_SCR, 32'h0);
    checkOutput("read data holds", read_data_tbman, 32'hAA22_CC44);

    // Simulation end flags
    busWrite(A_CTRL, 32'h3);
    checkOutput("sim_done set", 32'(sim_done), 32'h1);
    checkOutput("sim_pass set", 32'(sim_pass), 32'h1);
    busWrite(A_CTRL, 32'h1);
    checkOutput("sim_pass sticky", 32'(sim_pass), 32'h1);
    busRead(A_CTRL, rd);
    checkOutput("status after end", rd, 32'h13);
    busRead(8'h20, rd);
    checkOutput("unmapped read", rd, 32'h0);

    // Reset mid-operation discards queued bytes and flags
    busWrite(A_PUTC, 32'h41);
    checkOutput("queued before reset", 32'(char_valid), 32'h1);
    applyReset();
    checkOutput("mid reset char_valid", 32'(char_valid), 32'h0);
    checkOutput("mid reset sim_done", 32'(sim_done), 32'h0);
    checkOutput("mid reset timer_irq", 32'(timer_irq), 32'h0);
    checkOutput("mid reset read_data", read_data_tbman, 32'h0);
    busRead(A_SCR, rd);
    checkOutput("scratch after reset", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
